// File: rtl/fpu_wb_master.sv
// Wishbone classic initiator that runs one FPU command on the FPU register block:
// it writes the operands, polls status until a result is valid, then reads the result and exceptions back.
module fpu_wb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  OFS_A     = 8'h00,
  parameter logic [7:0]  OFS_B     = 8'h04,
  parameter logic [7:0]  OFS_C     = 8'h08,
  parameter logic [7:0]  OFS_FRM   = 8'h0C,
  parameter logic [7:0]  OFS_OP    = 8'h10,
  parameter logic [7:0]  OFS_STAT  = 8'h14,
  parameter logic [7:0]  OFS_RES   = 8'h18,
  parameter logic [7:0]  OFS_EXC   = 8'h1C,
  parameter logic [15:0] TIMEOUT   = 16'd1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_opa,
  input  logic [31:0] cmd_opb,
  input  logic [31:0] cmd_opc,
  input  logic [2:0]  cmd_frm,
  input  logic [12:0] cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_exc,
  output logic        rsp_timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [3:0]  dbg_state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WR_A   = 4'd1;
  localparam logic [3:0] S_WR_B   = 4'd2;
  localparam logic [3:0] S_WR_C   = 4'd3;
  localparam logic [3:0] S_WR_FRM = 4'd4;
  localparam logic [3:0] S_WR_OP  = 4'd5;
  localparam logic [3:0] S_POLL   = 4'd6;
  localparam logic [3:0] S_RD_RES = 4'd7;
  localparam logic [3:0] S_RD_EXC = 4'd8;
  localparam logic [3:0] S_RESP   = 4'd9;

  logic [3:0]  state;
  logic [3:0]  seq_next;
  logic [31:0] opa_q, opb_q, opc_q;
  logic [2:0]  frm_q;
  logic [12:0] op_q;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        cyc_q, we_q;
  logic [31:0] adr_q, dat_q;
  logic [31:0] result_q;
  logic [4:0]  exc_q;
  logic        timeout_q;

  assign cnt_inc = cnt + 16'd1;

  // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready; a response
  // transfers on an edge where rsp_valid && rsp_ready. Both sides hold their payload until then.
  assign cmd_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_result  = result_q;
  assign rsp_exc     = exc_q;
  assign rsp_timeout = timeout_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = {4{cyc_q}};
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign dbg_state   = state;

  // Successor of a bus state once its transfer is acknowledged.
  always_comb begin
    seq_next = S_IDLE;
    case (state)
      S_WR_A:   seq_next = S_WR_B;
      S_WR_B:   seq_next = op_q[10] ? S_WR_C : S_WR_FRM;
      S_WR_C:   seq_next = S_WR_FRM;
      S_WR_FRM: seq_next = S_WR_OP;
      S_WR_OP:  seq_next = S_POLL;
      S_POLL:   seq_next = (|wbm_dat_i[12:2]) ? S_RD_RES : S_POLL;
      S_RD_RES: seq_next = S_RD_EXC;
      S_RD_EXC: seq_next = S_RESP;
      default:  seq_next = S_IDLE;
    endcase
  end

  // {we, adr, dat} presented on the first cycle of bus state s.
  function automatic logic [64:0] bus_for(input logic [3:0] s);
    case (s)
      S_WR_B:   bus_for = {1'b1, BASE_ADDR + {24'd0, OFS_B},    opb_q};
      S_WR_C:   bus_for = {1'b1, BASE_ADDR + {24'd0, OFS_C},    opc_q};
      S_WR_FRM: bus_for = {1'b1, BASE_ADDR + {24'd0, OFS_FRM},  {29'd0, frm_q}};
      S_WR_OP:  bus_for = {1'b1, BASE_ADDR + {24'd0, OFS_OP},   {19'd0, op_q}};
      S_POLL:   bus_for = {1'b0, BASE_ADDR + {24'd0, OFS_STAT}, 32'd0};
      S_RD_RES: bus_for = {1'b0, BASE_ADDR + {24'd0, OFS_RES},  32'd0};
      S_RD_EXC: bus_for = {1'b0, BASE_ADDR + {24'd0, OFS_EXC},  32'd0};
      default:  bus_for = {1'b1, BASE_ADDR + {24'd0, OFS_A},    opa_q};
    endcase
  endfunction

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
      frm_q     <= '0;
      op_q      <= '0;
      cnt       <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      result_q  <= '0;
      exc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            opa_q     <= cmd_opa;
            opb_q     <= cmd_opb;
            opc_q     <= cmd_opc;
            frm_q     <= cmd_frm;
            op_q      <= cmd_op;
            cnt       <= '0;
            result_q  <= '0;
            exc_q     <= '0;
            timeout_q <= 1'b0;
            cyc_q     <= 1'b1;
            we_q      <= 1'b1;
            adr_q     <= BASE_ADDR + {24'd0, OFS_A};
            dat_q     <= cmd_opa;
            state     <= S_WR_A;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        S_WR_A, S_WR_B, S_WR_C, S_WR_FRM, S_WR_OP, S_POLL, S_RD_RES, S_RD_EXC: begin
          if (wbm_ack_i) begin
            if (state == S_RD_RES) result_q <= wbm_dat_i;
            if (state == S_RD_EXC) exc_q <= wbm_dat_i[4:0];
            if (seq_next == S_POLL && state == S_POLL) begin
              // Polls share one budget across reads rather than restarting per read.
              if (cnt_inc == TIMEOUT) begin
                state     <= S_RESP;
                timeout_q <= 1'b1;
                cyc_q     <= 1'b0;
                we_q      <= 1'b0;
                adr_q     <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (seq_next == S_RESP) begin
              state <= S_RESP;
              cyc_q <= 1'b0;
              we_q  <= 1'b0;
              adr_q <= '0;
              dat_q <= '0;
            end else begin
              state                <= seq_next;
              cnt                  <= '0;
              {we_q, adr_q, dat_q} <= bus_for(seq_next);
            end
          end else if (state != S_POLL) begin
            if (cnt_inc == TIMEOUT) begin
              state     <= S_RESP;
              timeout_q <= 1'b1;
              result_q  <= '0;
              exc_q     <= '0;
              cyc_q     <= 1'b0;
              we_q      <= 1'b0;
              adr_q     <= '0;
              dat_q     <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cyc_q <= 1'b0;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_wb_master.sv
// Bench for fpu_wb_master: a behavioural Wishbone FPU slave plus a transfer-list model of each command.
module tb_fpu_wb_master;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_opa, cmd_opb, cmd_opc;
  logic [2:0]  cmd_frm;
  logic [12:0] cmd_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_exc;
  logic        rsp_timeout;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack;
  logic [3:0]  dbg_state;

  fpu_wb_master dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_opc(cmd_opc),
    .cmd_frm(cmd_frm), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_exc(rsp_exc), .rsp_timeout(rsp_timeout),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // slave configuration and observation
  logic        hang_en = 1'b0;
  logic [31:0] hang_adr = '0;
  logic        stray_ack = 1'b0;
  int          max_wait = 0;
  int          polls_left = 0;
  int          wait_left = 0;
  logic [31:0] stat_val = '0, res_val = '0, exc_val = '0;
  int          gap_cycles = 0, proto_errs = 0, hang_cycles = 0;
  logic [64:0] log_q[$];
  logic [64:0] exp_q[$];

  // Slave: ack is asserted for one edge when a transfer's wait count expires.
  always @(negedge clk) begin
    ack = 1'b0;
    if (!rst) begin
      if (cyc) begin
        if (hang_en && adr == hang_adr) hang_cycles++;
        else if (wait_left > 0) wait_left--;
        else begin
          ack = 1'b1;
          if (!we) begin
            if (adr == BASE + 32'h14) begin
              if (polls_left > 0) begin
                dat_i = $urandom & ~32'h0000_1FFC;
                polls_left--;
              end else dat_i = stat_val;
            end else if (adr == BASE + 32'h18) dat_i = res_val;
            else if (adr == BASE + 32'h1C) dat_i = exc_val;
            else dat_i = $urandom;
          end
          log_q.push_back({we, adr, we ? dat_o : 32'h0});
          wait_left = $urandom_range(0, max_wait);
        end
        if (stb !== 1'b1 || sel !== 4'hF) proto_errs++;
      end else begin
        ack = stray_ack;
      end
      if (!cmd_ready && !rsp_valid && !cyc) gap_cycles++;
    end
  end

  // driver
  task automatic send_cmd(input logic [31:0] a, b, c, input logic [2:0] f, input logic [12:0] op);
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
    end
    cmd_opa = a; cmd_opb = b; cmd_opc = c; cmd_frm = f; cmd_op = op;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_opa = $urandom; cmd_opb = $urandom; cmd_opc = $urandom; cmd_frm = 3'($urandom); cmd_op = 13'($urandom);
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL cmd_ready_busy: got %b expected 0", cmd_ready);
    end
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", limit);
    end
  endtask

  task automatic handshake_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsp_release: got rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready);
    end
  endtask

  // One complete command against the model: expected transfer list and response.
  task automatic run_cmd(input logic [31:0] a, b, c, input logic [2:0] f, input logic [12:0] op,
                         input int waits, input int zpolls, input logic [31:0] stat, res, exc,
                         input bit stall);
    bit bad;
    logic [31:0] held_res;
    logic [4:0]  held_exc;
    max_wait = waits; polls_left = zpolls; wait_left = 0;
    stat_val = stat; res_val = res; exc_val = exc;
    exp_q.delete();
    exp_q.push_back({1'b1, BASE + 32'h00, a});
    exp_q.push_back({1'b1, BASE + 32'h04, b});
    if (op[10]) exp_q.push_back({1'b1, BASE + 32'h08, c});
    exp_q.push_back({1'b1, BASE + 32'h0C, {29'd0, f}});
    exp_q.push_back({1'b1, BASE + 32'h10, {19'd0, op}});
    for (int i = 0; i <= zpolls; i++) exp_q.push_back({1'b0, BASE + 32'h14, 32'h0});
    exp_q.push_back({1'b0, BASE + 32'h18, 32'h0});
    exp_q.push_back({1'b0, BASE + 32'h1C, 32'h0});
    log_q.delete();
    gap_cycles = 0; proto_errs = 0;
    send_cmd(a, b, c, f, op);
    wait_rsp(5000);
    tests_run++;
    if (rsp_result !== res) begin
      tests_failed++;
      $display("FAIL rsp_result: got %h expected %h", rsp_result, res);
    end
    tests_run++;
    if (rsp_exc !== exc[4:0] || rsp_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsp_exc: got exc=%h timeout=%b expected %h/0", rsp_exc, rsp_timeout, exc[4:0]);
    end
    bad = (log_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL transfers: got %0d transfers expected %0d (or content differs)", log_q.size(), exp_q.size());
    end
    tests_run++;
    if (gap_cycles != 0 || proto_errs != 0 || cyc !== 1'b0) begin
      tests_failed++;
      $display("FAIL bus_shape: got gaps=%0d proto=%0d cyc=%b expected 0/0/0", gap_cycles, proto_errs, cyc);
    end
    if (stall) begin
      held_res = rsp_result; held_exc = rsp_exc;
      bad = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || cyc !== 1'b0 ||
            rsp_result !== held_res || rsp_exc !== held_exc) bad = 1'b1;
      end
      tests_run++;
      if (bad) begin
        tests_failed++;
        $display("FAIL stall_hold: got result=%h exc=%h valid=%b ready=%b expected %h/%h/1/0",
                 rsp_result, rsp_exc, rsp_valid, cmd_ready, held_res, held_exc);
      end
    end
    handshake_rsp();
  endtask

  task automatic test_reset();
    tests_run++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0 || we !== 1'b0 ||
        sel !== 4'h0 || adr !== 32'h0 || dat_o !== 32'h0 || rsp_result !== 32'h0 ||
        rsp_exc !== 5'h0 || rsp_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got ready=%b valid=%b cyc=%b adr=%h dat=%h res=%h expected 1/0/0/0/0/0",
               cmd_ready, rsp_valid, cyc, adr, dat_o, rsp_result);
    end
  endtask

  task automatic test_add();
    run_cmd(32'h3F80_0000, 32'h4000_0000, 32'h0, 3'd0, 13'h0100, 0, 0,
            32'h0000_0100, 32'h4040_0000, 32'h0, 1'b0);
  endtask

  task automatic test_fma();
    run_cmd(32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 3'd1, 13'h0400, 0, 0,
            32'h0000_1000, 32'h40E0_0000, 32'h0, 1'b0);
  endtask

  task automatic test_div();
    run_cmd(32'h4120_0000, 32'h4040_0000, 32'h0, 3'd0, 13'h0200, 0, 20,
            32'h0000_0800, 32'h4055_5555, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [12:0] op;
      op = 13'($urandom);
      run_cmd($urandom, $urandom, $urandom, 3'($urandom), op, $urandom_range(0, 3), $urandom_range(0, 6),
              $urandom | (32'h4 << $urandom_range(0, 10)), $urandom, $urandom, 1'b0);
    end
  endtask

  task automatic test_timeout();
    hang_en = 1'b1; hang_adr = BASE + 32'h04; hang_cycles = 0;
    max_wait = 0; wait_left = 0; exc_val = 32'h1F; res_val = 32'hDEAD_BEEF;
    log_q.delete();
    send_cmd(32'h1111_1111, 32'h2222_2222, 32'h0, 3'd2, 13'h0101);
    wait_rsp(3000);
    tests_run++;
    if (hang_cycles != 1023) begin
      tests_failed++;
      $display("FAIL timeout_len: got %0d cycles expected 1023", hang_cycles);
    end
    tests_run++;
    if (rsp_timeout !== 1'b1 || rsp_result !== 32'h0 || rsp_exc !== 5'h0 || cyc !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_rsp: got to=%b res=%h exc=%h cyc=%b expected 1/0/0/0",
               rsp_timeout, rsp_result, rsp_exc, cyc);
    end
    tests_run++;
    if (log_q.size() != 1) begin
      tests_failed++;
      $display("FAIL timeout_xfers: got %0d transfers expected 1", log_q.size());
    end
    hang_en = 1'b0;
    handshake_rsp();
  endtask

  task automatic test_stall();
    run_cmd($urandom, $urandom, $urandom, 3'd3, 13'h0008, 1, 2, 32'h0000_0020, $urandom, $urandom, 1'b1);
  endtask

  task automatic test_stray_ack();
    bit bad = 1'b0;
    stray_ack = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (cmd_ready !== 1'b1 || cyc !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
    end
    stray_ack = 1'b0;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL stray_ack: got ready=%b cyc=%b expected 1/0", cmd_ready, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit bad = 1'b0;
    max_wait = 0; polls_left = 40; stat_val = 32'h4; res_val = $urandom; exc_val = 0;
    send_cmd($urandom, $urandom, $urandom, 3'd0, 13'h0004);
    while (!(cyc === 1'b1 && adr == BASE + 32'h14) && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 200) begin
      tests_failed++;
      $display("FAIL reach_poll: got no STAT read within 200 cycles, expected one");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (cyc !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got cyc=%b ready=%b valid=%b expected 0/1/0", cyc, cmd_ready, rsp_valid);
    end
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cyc !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL reset_quiet: got activity after reset, expected none");
    end
    run_cmd($urandom, $urandom, $urandom, 3'd4, 13'h0401, 1, 3, 32'h0000_0004, $urandom, $urandom, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opa = '0; cmd_opb = '0; cmd_opc = '0; cmd_frm = '0; cmd_op = '0;
    ack = 1'b0; dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_add();
    test_fma();
    test_div();
    test_random();
    test_timeout();
    test_stall();
    test_stray_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
